// File: rtl/serial_subtractor_if.sv
// Start/Done handshake and result bus of the bit-serial subtractor.
// The master issues operands, the slave (the subtractor) returns result and flags.
interface serial_subtractor_if #(
    parameter int WIDTH = 24
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] DIFF;
    logic             BorrowOut;
    logic             Zero;
    logic             Negative;
    logic             Overflow;

    modport master (
        output Start, A, B,
        input  Busy, Done, DIFF, BorrowOut, Zero, Negative, Overflow
    );

    modport slave (
        input  Start, A, B,
        output Busy, Done, DIFF, BorrowOut, Zero, Negative, Overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: DIFF = A - B, one bit per clock, LSB first,
// built from a single full-subtractor cell and a registered borrow.
//
// state | meaning
// IDLE  | waiting for Start, previous result and flags held
// RUN   | one operand bit pair consumed per edge, WIDTH edges total
// DONE  | result valid, Done pulsed; Start here begins the next operation at once
module serial_subtractor #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 5
) (
    input logic                Clock,
    input logic                ResetN,
    serial_subtractor_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t stateNext;

    logic [WIDTH-1:0] shA;
    logic [WIDTH-1:0] shB;
    logic [WIDTH-1:0] resReg;
    logic [CNT_W-1:0] cnt;
    logic             borrow;
    logic             signA;
    logic             signB;

    logic [WIDTH-1:0] diffReg;
    logic             borrowOutReg;
    logic             zeroReg;
    logic             negativeReg;
    logic             overflowReg;

    logic             accept;
    logic             lastBit;
    logic             aBit;
    logic             bBit;
    logic             dBit;
    logic             borrowNext;
    logic [WIDTH-1:0] resNext;

    // Start is only honoured when no operation is in flight.
    assign accept  = bus.Start && ((state == IDLE) || (state == DONE));
    assign lastBit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

    assign aBit       = shA[0];
    assign bBit       = shB[0];
    assign dBit       = aBit ^ bBit ^ borrow;
    assign borrowNext = (~aBit & bBit) | (~aBit & borrow) | (bBit & borrow);
    assign resNext    = {dBit, resReg[WIDTH-1:1]};

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (lastBit) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    stateNext = RUN;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.Busy = 1'b0;
        bus.Done = 1'b0;
        case (state)
            RUN:     bus.Busy = 1'b1;
            DONE:    bus.Done = 1'b1;
            default: begin
                bus.Busy = 1'b0;
                bus.Done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            shA    <= '0;
            shB    <= '0;
            resReg <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            signA  <= 1'b0;
            signB  <= 1'b0;
        end else if (accept) begin
            shA    <= bus.A;
            shB    <= bus.B;
            cnt    <= '0;
            borrow <= 1'b0;
            signA  <= bus.A[WIDTH-1];
            signB  <= bus.B[WIDTH-1];
        end else if (state == RUN) begin
            shA    <= shA >> 1;
            shB    <= shB >> 1;
            resReg <= resNext;
            cnt    <= cnt + CNT_W'(1);
            borrow <= borrowNext;
        end
    end

    // Result and flags only move on the edge that completes an operation.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            diffReg      <= '0;
            borrowOutReg <= 1'b0;
            zeroReg      <= 1'b1;
            negativeReg  <= 1'b0;
            overflowReg  <= 1'b0;
        end else if (lastBit) begin
            diffReg      <= resNext;
            borrowOutReg <= borrowNext;
            zeroReg      <= (resNext == '0);
            negativeReg  <= resNext[WIDTH-1];
            overflowReg  <= (signA != signB) && (resNext[WIDTH-1] != signA);
        end
    end

    assign bus.DIFF      = diffReg;
    assign bus.BorrowOut = borrowOutReg;
    assign bus.Zero      = zeroReg;
    assign bus.Negative  = negativeReg;
    assign bus.Overflow  = overflowReg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes arithmetic expectations,
// a negedge monitor checks Busy/Done timing, results and hold behaviour.
module tb_serial_subtractor;
    localparam int W = 24;

    logic Clock;
    logic ResetN;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W), .CNT_W(5)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [W-1:0] diff;
        logic         bo;
        logic         z;
        logic         n;
        logic         o;
        int           acceptCyc;
        int           doneCyc;
    } exp_t;

    exp_t sbQ[$];
    exp_t lastExp;
    exp_t resetExp;
    int   cyc = 0;
    int   nCmp = 0;
    int   nBad = 0;
    logic prevRstLow = 1'b1;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endfunction

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, int acc);
        exp_t e;
        int   sa;
        int   sb;
        int   full;
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        full = sa - sb;
        e.diff = a - b;
        e.bo   = (a < b);
        e.z    = (e.diff == 0);
        e.n    = e.diff[W-1];
        e.o    = (full > 8388607) || (full < -8388608);
        e.acceptCyc = acc;
        e.doneCyc   = acc + W;
        return e;
    endfunction

    function automatic logic [31:0] packOut();
        return {4'b0, bus.DIFF, bus.BorrowOut, bus.Zero, bus.Negative, bus.Overflow};
    endfunction

    function automatic logic [31:0] packExp(exp_t e);
        return {4'b0, e.diff, e.bo, e.z, e.n, e.o};
    endfunction

    always @(negedge Clock) begin : monitor
        exp_t e;
        logic expBusy;
        logic expDone;
        if (prevRstLow) begin
            sbQ.delete();
            lastExp = resetExp;
            chk("reset_busy", {31'b0, bus.Busy}, 32'd0);
            chk("reset_done", {31'b0, bus.Done}, 32'd0);
            chk("reset_outputs", packOut(), packExp(resetExp));
        end else begin
            expBusy = (sbQ.size() > 0) && (cyc >= sbQ[0].acceptCyc) && (cyc < sbQ[0].doneCyc);
            expDone = (sbQ.size() > 0) && (cyc == sbQ[0].doneCyc);
            chk("busy", {31'b0, bus.Busy}, {31'b0, expBusy});
            chk("done", {31'b0, bus.Done}, {31'b0, expDone});
            if (expDone) begin
                e = sbQ.pop_front();
                chk("diff", {8'b0, bus.DIFF}, {8'b0, e.diff});
                chk("borrow_out", {31'b0, bus.BorrowOut}, {31'b0, e.bo});
                chk("zero", {31'b0, bus.Zero}, {31'b0, e.z});
                chk("negative", {31'b0, bus.Negative}, {31'b0, e.n});
                chk("overflow", {31'b0, bus.Overflow}, {31'b0, e.o});
                lastExp = e;
            end else begin
                chk("hold", packOut(), packExp(lastExp));
            end
        end
        prevRstLow = !ResetN;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        while (bus.Busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            nCmp++;
            nBad++;
            $display("FAIL issue_timeout at cycle %0d: busy stuck %b expected 0", cyc, bus.Busy);
            return;
        end
        bus.Start = 1'b1;
        bus.A = a;
        bus.B = b;
        sbQ.push_back(model(a, b, cyc + 1));
        tick();
        bus.Start = 1'b0;
        bus.A = W'($urandom);
        bus.B = W'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            nCmp++;
            nBad++;
            $display("FAIL drain_timeout at cycle %0d: pending %0d expected 0", cyc, sbQ.size());
        end
    endtask

    initial begin : driver
        int acc1;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        resetExp.diff = '0;
        resetExp.bo = 1'b0;
        resetExp.z = 1'b1;
        resetExp.n = 1'b0;
        resetExp.o = 1'b0;
        resetExp.acceptCyc = 0;
        resetExp.doneCyc = 0;
        lastExp = resetExp;

        ResetN = 1'b0;
        bus.Start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        repeat (2) @(posedge Clock);
        #1;
        ResetN = 1'b1;
        tick();

        issue(24'h000005, 24'h000003);
        issue(24'h000003, 24'h000005);
        issue(24'h7FFFFF, 24'hFFFFFF);
        issue(24'h800000, 24'h000001);
        issue(24'hABCDEF, 24'hABCDEF);

        // Start pulse mid-RUN must be ignored.
        repeat (5) tick();
        bus.Start = 1'b1;
        bus.A = 24'h111111;
        bus.B = 24'h000777;
        tick();
        bus.Start = 1'b0;
        drain();

        // Start held high across two operations.
        tick();
        bus.Start = 1'b1;
        bus.A = 24'd10;
        bus.B = 24'd4;
        acc1 = cyc + 1;
        sbQ.push_back(model(24'd10, 24'd4, acc1));
        tick();
        bus.A = 24'd0;
        bus.B = 24'd1;
        sbQ.push_back(model(24'd0, 24'd1, acc1 + W + 1));
        repeat (W + 1) tick();
        bus.Start = 1'b0;
        drain();

        // Reset during RUN aborts the operation.
        issue(24'h123456, 24'h000001);
        repeat (10) tick();
        ResetN = 1'b0;
        tick();
        ResetN = 1'b1;
        tick();
        issue(24'h123456, 24'h000001);
        drain();

        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: ra = 24'h000000;
                2: rb = 24'h800000;
                default: ;
            endcase
            issue(ra, rb);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 40)) tick();
        end
        drain();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
